ysyx_24090003_mem_arbiter: RTL and testbench
============================================

YSYX_24090003_MEM_ARBITER -- requirements
Module: ysyx_24090003_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PRIO_LSU, 1, 1 = fixed LSU priority on tie; 0 = round-robin.
  TIMEOUT_CYC, 255, max cycles in REQ+RESP before error response; 0 disables timeout.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  i_clk  in  1  clock, rising edge
  i_rst_n  in  1  synchronous active-low reset
  i_if_req_valid  in  1  IFU fetch request
  i_if_addr  in  32  IFU fetch address
  o_if_req_ready  out  1  IFU request accepted this cycle
  o_if_resp_valid  out  1  IFU response pulse
  o_if_rdata  out  32  IFU read data
  o_if_resp_err  out  1  IFU response error
  i_ls_req_valid  in  1  LSU request
  i_ls_addr  in  32  LSU address
  i_ls_wen  in  1  LSU write (1) / read (0)
  i_ls_wdata  in  32  LSU write data
  i_ls_wmask  in  4  LSU byte mask
  o_ls_req_ready  out  1  LSU request accepted this cycle
  o_ls_resp_valid  out  1  LSU response pulse
  o_ls_rdata  out  32  LSU read data
  o_ls_resp_err  out  1  LSU response error
  o_mem_req_valid  out  1  downstream request valid
  i_mem_req_ready  in  1  downstream request accepted
  o_mem_addr  out  32  latched address
  o_mem_wen  out  1  latched write enable (0 for IFU)
  o_mem_wdata  out  32  latched write data (0 for IFU)
  o_mem_wmask  out  4  latched mask (0 for IFU)
  i_mem_resp_valid  in  1  downstream response valid
  i_mem_rdata  in  32  downstream read data
  i_mem_resp_err  in  1  downstream error
  o_busy  out  1  state != IDLE
  o_grant_id  out  1  owner of current transaction: 0 IFU, 1 LSU

Function
REQ-003 FSM SHALL have states IDLE, REQ, RESP; exactly one outstanding transaction.
REQ-004 IDLE: if any req_valid, select winner, assert only winner's req_ready combinationally that cycle, latch addr/wen/wdata/wmask and owner, go REQ next cycle; else stay.
REQ-005 Arbitration with PRIO_LSU=1: LSU wins when both valid; PRIO_LSU=0: on tie grant requester not granted last; last-grant register updates on every accept.
REQ-006 Single requester SHALL always win regardless of mode; loser sees req_ready=0 and must hold its request.
REQ-007 REQ: o_mem_req_valid=1 with latched fields stable; on i_mem_req_ready=1 go RESP.
REQ-008 RESP: on i_mem_resp_valid=1, owner's resp_valid=1 same cycle (combinational), rdata=i_mem_rdata, err=i_mem_resp_err; go IDLE.
REQ-009 Non-owner resp_valid SHALL be 0 at all times; rdata outputs SHALL be 0 when resp_valid=0.
REQ-010 Requesters SHALL always accept responses (no resp_ready); response is a one-cycle pulse.
REQ-011 Timeout counter SHALL clear on accept, increment each cycle in REQ or RESP, saturate at TIMEOUT_CYC.
REQ-012 Counter == TIMEOUT_CYC-1 with no completing handshake SHALL force owner resp_valid=1, err=1, rdata=0, o_mem_req_valid deasserted next cycle, go IDLE.
REQ-013 i_mem_resp_valid in IDLE or REQ SHALL be ignored, no response generated.
REQ-014 New request SHALL NOT be accepted in the cycle a response is delivered; earliest accept is next cycle (IDLE).
REQ-015 Minimum latency accept-to-response: 2 cycles (accept cycle N, mem_req cycle N+1 with ready, resp cycle N+2).

Reset
REQ-016 i_rst_n=0 at a rising edge SHALL force IDLE, counter 0, last-grant=LSU, latched fields 0.
REQ-017 During and after reset all outputs SHALL be 0 until a new accept; reset mid-transaction aborts it with no response.

Verification
REQ-018 IFU-only read addr 0x80000000, mem ready/resp immediate, rdata 0x00000413 -> if_req_ready cycle 0, mem_req_valid cycle 1, if_resp_valid with 0x00000413 cycle 2.
REQ-019 Both valid same cycle, PRIO_LSU=1 -> ls_req_ready=1, if_req_ready=0; IFU granted only after LSU response.
REQ-020 PRIO_LSU=0, both held valid for 4 transactions -> grant order IFU, LSU, IFU, LSU.
REQ-021 LSU write addr 0x80001000 wdata 0xDEADBEEF wmask 0xF, mem_req_ready held low 3 cycles -> mem fields stable all 4 REQ cycles, ls_resp_valid after response.
REQ-022 TIMEOUT_CYC=8, memory never responds -> owner resp_valid=1, err=1, rdata=0 at 8th cycle after accept; late mem response then ignored.
REQ-023 Reset asserted in RESP -> no resp_valid pulse, o_busy=0 next cycle, following IFU request served normally.

Source files
------------

// File: rtl/ysyx_24090003_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single-outstanding memory port.
// Winner's request fields are latched at accept; stuck transactions end with an error response.
//
// state | meaning
// IDLE  | no transaction owned; arbitrate and accept one request
// REQ   | latched request presented downstream, waiting for i_mem_req_ready
// RESP  | downstream accepted, waiting for i_mem_resp_valid
module ysyx_24090003_mem_arbiter #(
  parameter bit          PRIO_LSU    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_if_req_valid,
  input  logic [31:0] i_if_addr,
  output logic        o_if_req_ready,
  output logic        o_if_resp_valid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_resp_err,

  input  logic        i_ls_req_valid,
  input  logic [31:0] i_ls_addr,
  input  logic        i_ls_wen,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_wmask,
  output logic        o_ls_req_ready,
  output logic        o_ls_resp_valid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_resp_err,

  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wmask,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_resp_err,

  output logic        o_busy,
  output logic        o_grant_id
);

  localparam int unsigned   CW       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_last_ls;
  logic [31:0]   r_addr;
  logic          r_wen;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wmask;
  logic [CW-1:0] r_cnt;

  logic w_tie;
  logic w_grant_ls;
  logic w_accept;
  logic w_resp_hs;
  logic w_timeout;
  logic w_fire;

  // Round-robin on a tie hands the grant to whoever did not win last time.
  assign w_tie      = i_if_req_valid & i_ls_req_valid;
  assign w_grant_ls = w_tie ? (PRIO_LSU | ~r_last_ls) : i_ls_req_valid;
  assign w_accept   = i_rst_n & (r_state == S_IDLE) & (i_if_req_valid | i_ls_req_valid);

  assign w_resp_hs  = (r_state == S_RESP) & i_mem_resp_valid;
  assign w_timeout  = (TIMEOUT_CYC != 0) & (r_state != S_IDLE) & (r_cnt == CNT_LAST) & ~w_resp_hs;
  // Responses are suppressed while reset is held so an aborted transaction never completes.
  assign w_fire     = i_rst_n & (w_resp_hs | w_timeout);

  assign o_if_req_ready  = w_accept & ~w_grant_ls;
  assign o_ls_req_ready  = w_accept & w_grant_ls;

  assign o_if_resp_valid = w_fire & ~r_owner;
  assign o_ls_resp_valid = w_fire & r_owner;
  assign o_if_rdata      = (w_fire & ~r_owner & w_resp_hs) ? i_mem_rdata : '0;
  assign o_ls_rdata      = (w_fire & r_owner & w_resp_hs) ? i_mem_rdata : '0;
  assign o_if_resp_err   = w_fire & ~r_owner & (w_timeout | i_mem_resp_err);
  assign o_ls_resp_err   = w_fire & r_owner & (w_timeout | i_mem_resp_err);

  assign o_mem_req_valid = (r_state == S_REQ);
  assign o_mem_addr      = r_addr;
  assign o_mem_wen       = r_wen;
  assign o_mem_wdata     = r_wdata;
  assign o_mem_wmask     = r_wmask;
  assign o_busy          = (r_state != S_IDLE);
  assign o_grant_id      = r_owner;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last_ls <= 1'b1;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_REQ;
            r_owner   <= w_grant_ls;
            r_last_ls <= w_grant_ls;
            r_addr    <= w_grant_ls ? i_ls_addr : i_if_addr;
            r_wen     <= w_grant_ls & i_ls_wen;
            r_wdata   <= w_grant_ls ? i_ls_wdata : '0;
            r_wmask   <= w_grant_ls ? i_ls_wmask : '0;
            r_cnt     <= '0;
          end
        end
        S_REQ: begin
          if (w_timeout) begin
            r_state <= S_IDLE;
          end else if (i_mem_req_ready) begin
            r_state <= S_RESP;
          end
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (w_fire) begin
            r_state <= S_IDLE;
          end
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// Bench for ysyx_24090003_mem_arbiter: a fixed-priority and a round-robin instance share stimulus
// and are compared every cycle against a transaction-level model, plus directed literal checks.
module tb_ysyx_24090003_mem_arbiter;

  localparam int TO = 8;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst_n, ifv, lsv, ls_wen, mrr, mrv, merr;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_wmask;

  logic [1:0]  if_rdy, if_rv, if_err, ls_rdy, ls_rv, ls_err, mem_v, mem_wen, busy, gid;
  logic [31:0] if_rd [2];
  logic [31:0] ls_rd [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wmask [2];

  // Instance 0: fixed LSU priority. Instance 1: round-robin.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_24090003_mem_arbiter #(.PRIO_LSU(g == 0), .TIMEOUT_CYC(TO)) u_dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_if_req_valid   (ifv),
      .i_if_addr        (if_addr),
      .o_if_req_ready   (if_rdy[g]),
      .o_if_resp_valid  (if_rv[g]),
      .o_if_rdata       (if_rd[g]),
      .o_if_resp_err    (if_err[g]),
      .i_ls_req_valid   (lsv),
      .i_ls_addr        (ls_addr),
      .i_ls_wen         (ls_wen),
      .i_ls_wdata       (ls_wdata),
      .i_ls_wmask       (ls_wmask),
      .o_ls_req_ready   (ls_rdy[g]),
      .o_ls_resp_valid  (ls_rv[g]),
      .o_ls_rdata       (ls_rd[g]),
      .o_ls_resp_err    (ls_err[g]),
      .o_mem_req_valid  (mem_v[g]),
      .i_mem_req_ready  (mrr),
      .o_mem_addr       (mem_addr[g]),
      .o_mem_wen        (mem_wen[g]),
      .o_mem_wdata      (mem_wdata[g]),
      .o_mem_wmask      (mem_wmask[g]),
      .i_mem_resp_valid (mrv),
      .i_mem_rdata      (mem_rdata),
      .i_mem_resp_err   (merr),
      .o_busy           (busy[g]),
      .o_grant_id       (gid[g])
    );
  end

  // Transaction model: one open transaction, whether memory took it, and its age in cycles.
  bit          m_busy [2];
  bit          m_acc  [2];
  bit          m_owner[2];
  bit          m_last [2];
  int          m_age  [2];
  logic [31:0] m_addr [2];
  logic        m_wen  [2];
  logic [31:0] m_wdata[2];
  logic [3:0]  m_wmask[2];
  bit          e_wls [2];
  bit          e_acc [2];
  bit          e_fire[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k]  = 1'b0;
    m_acc[k]   = 1'b0;
    m_owner[k] = 1'b0;
    m_last[k]  = 1'b1;
    m_age[k]   = 0;
    m_addr[k]  = '0;
    m_wen[k]   = 1'b0;
    m_wdata[k] = '0;
    m_wmask[k] = '0;
  endtask

  task automatic settle();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit ok, to;
      e_wls[k]  = (ifv && lsv) ? (k == 0 || !m_last[k]) : lsv;
      e_acc[k]  = i_rst_n && !m_busy[k] && (ifv || lsv);
      ok        = i_rst_n && m_busy[k] && m_acc[k] && mrv;
      to        = i_rst_n && m_busy[k] && !ok && (m_age[k] + 1 == TO);
      e_fire[k] = ok || to;
      chk($sformatf("i%0d if_req_ready", k), 32'(if_rdy[k]), 32'(e_acc[k] && !e_wls[k]));
      chk($sformatf("i%0d ls_req_ready", k), 32'(ls_rdy[k]), 32'(e_acc[k] && e_wls[k]));
      chk($sformatf("i%0d if_resp_valid", k), 32'(if_rv[k]), 32'(e_fire[k] && !m_owner[k]));
      chk($sformatf("i%0d ls_resp_valid", k), 32'(ls_rv[k]), 32'(e_fire[k] && m_owner[k]));
      chk($sformatf("i%0d if_rdata", k), if_rd[k], (ok && !m_owner[k]) ? mem_rdata : 32'h0);
      chk($sformatf("i%0d ls_rdata", k), ls_rd[k], (ok && m_owner[k]) ? mem_rdata : 32'h0);
      chk($sformatf("i%0d if_resp_err", k), 32'(if_err[k]), 32'(e_fire[k] && !m_owner[k] && (to || merr)));
      chk($sformatf("i%0d ls_resp_err", k), 32'(ls_err[k]), 32'(e_fire[k] && m_owner[k] && (to || merr)));
      chk($sformatf("i%0d mem_req_valid", k), 32'(mem_v[k]), 32'(m_busy[k] && !m_acc[k]));
      chk($sformatf("i%0d mem_addr", k), mem_addr[k], m_addr[k]);
      chk($sformatf("i%0d mem_wen", k), 32'(mem_wen[k]), 32'(m_wen[k]));
      chk($sformatf("i%0d mem_wdata", k), mem_wdata[k], m_wdata[k]);
      chk($sformatf("i%0d mem_wmask", k), 32'(mem_wmask[k]), 32'(m_wmask[k]));
      chk($sformatf("i%0d busy", k), 32'(busy[k]), 32'(m_busy[k]));
      chk($sformatf("i%0d grant_id", k), 32'(gid[k]), 32'(m_owner[k]));
    end
  endtask

  task automatic adv();
    @(posedge i_clk);
    for (int k = 0; k < 2; k++) begin
      if (!i_rst_n) begin
        model_reset(k);
      end else if (m_busy[k]) begin
        if (e_fire[k]) begin
          m_busy[k] = 1'b0;
        end else begin
          if (!m_acc[k] && mrr) m_acc[k] = 1'b1;
          m_age[k]++;
        end
      end else if (e_acc[k]) begin
        m_busy[k]  = 1'b1;
        m_acc[k]   = 1'b0;
        m_age[k]   = 0;
        m_owner[k] = e_wls[k];
        m_last[k]  = e_wls[k];
        m_addr[k]  = e_wls[k] ? ls_addr : if_addr;
        m_wen[k]   = e_wls[k] && ls_wen;
        m_wdata[k] = e_wls[k] ? ls_wdata : 32'h0;
        m_wmask[k] = e_wls[k] ? ls_wmask : 4'h0;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic drive_idle();
    i_rst_n = 1'b1; ifv = 1'b0; lsv = 1'b0; ls_wen = 1'b0;
    mrr = 1'b0; mrv = 1'b0; merr = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0; ls_wmask = '0;
  endtask

  initial begin
    int g0[$];
    int g1[$];
    drive_idle();
    i_rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    @(posedge i_clk);
    @(negedge i_clk);

    // Reset held with requests and memory activity present.
    ifv = 1'b1; lsv = 1'b1; mrr = 1'b1; mrv = 1'b1; mem_rdata = 32'h1111_2222;
    settle();
    chk("rst busy", 32'(busy[0]), 0);
    chk("rst ls_req_ready", 32'(ls_rdy[0]), 0);
    chk("rst mem_addr", mem_addr[1], 0);
    adv();

    // IFU-only read with immediate memory.
    drive_idle();
    ifv = 1'b1; if_addr = 32'h8000_0000; mrr = 1'b1; mrv = 1'b1; mem_rdata = 32'h0000_0413;
    settle();
    chk("ifu c0 if_req_ready", 32'(if_rdy[0]), 1);
    adv();
    ifv = 1'b0; if_addr = 32'h0000_1234;
    settle();
    chk("ifu c1 mem_req_valid", 32'(mem_v[0]), 1);
    chk("ifu c1 mem_addr", mem_addr[0], 32'h8000_0000);
    chk("ifu c1 early resp ignored", 32'(if_rv[0]), 0);
    adv();
    settle();
    chk("ifu c2 if_resp_valid", 32'(if_rv[0]), 1);
    chk("ifu c2 if_rdata", if_rd[0], 32'h0000_0413);
    adv();
    settle();
    chk("ifu c3 idle", 32'(busy[0]), 0);
    adv();

    drive_idle();
    i_rst_n = 1'b0;
    settle();
    adv();

    // Both requesters held valid: fixed priority vs round-robin grant order.
    drive_idle();
    ifv = 1'b1; lsv = 1'b1; if_addr = 32'h8000_0100; ls_addr = 32'h8000_0200;
    mrr = 1'b1; mrv = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (c == 0) begin
        chk("tie prio ls_req_ready", 32'(ls_rdy[0]), 1);
        chk("tie prio if_req_ready", 32'(if_rdy[0]), 0);
      end
      if (if_rdy[0]) g0.push_back(0);
      if (ls_rdy[0]) g0.push_back(1);
      if (if_rdy[1]) g1.push_back(0);
      if (ls_rdy[1]) g1.push_back(1);
      adv();
    end
    chk("prio grant count", 32'(g0.size()), 4);
    chk("rr grant count", 32'(g1.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("prio grant %0d", i), (i < g0.size()) ? 32'(g0[i]) : 32'hFFFF_FFFF, 1);
      chk($sformatf("rr grant %0d", i), (i < g1.size()) ? 32'(g1[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    end

    // LSU write with downstream stalling three cycles.
    drive_idle();
    lsv = 1'b1; ls_addr = 32'h8000_1000; ls_wen = 1'b1; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF;
    settle();
    chk("wr accept", 32'(ls_rdy[0]), 1);
    adv();
    lsv = 1'b0; ls_addr = 32'h0; ls_wen = 1'b0; ls_wdata = 32'h0; ls_wmask = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      mrr = (c == 4);
      settle();
      chk($sformatf("wr c%0d mem_req_valid", c), 32'(mem_v[0]), 1);
      chk($sformatf("wr c%0d mem_addr", c), mem_addr[0], 32'h8000_1000);
      chk($sformatf("wr c%0d mem_wdata", c), mem_wdata[0], 32'hDEAD_BEEF);
      chk($sformatf("wr c%0d mem_wmask", c), 32'(mem_wmask[0]), 32'hF);
      chk($sformatf("wr c%0d mem_wen", c), 32'(mem_wen[0]), 1);
      adv();
    end
    mrr = 1'b0; mrv = 1'b1;
    settle();
    chk("wr ls_resp_valid", 32'(ls_rv[0]), 1);
    chk("wr if_resp_valid", 32'(if_rv[0]), 0);
    adv();

    // Memory never responds: timeout on the 8th cycle after accept.
    drive_idle();
    ifv = 1'b1; if_addr = 32'h8000_0040; mem_rdata = 32'hDEAD_0000;
    settle();
    chk("to accept", 32'(if_rdy[0]), 1);
    adv();
    ifv = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      mrr = (c == 1);
      settle();
      if (c < 8) begin
        chk($sformatf("to c%0d no resp", c), 32'(if_rv[0]), 0);
      end else begin
        chk("to c8 if_resp_valid", 32'(if_rv[0]), 1);
        chk("to c8 if_resp_err", 32'(if_err[0]), 1);
        chk("to c8 if_rdata", if_rd[0], 0);
      end
      adv();
    end
    mrv = 1'b1;
    settle();
    chk("to late resp ignored", 32'(if_rv[0]), 0);
    chk("to idle after", 32'(busy[0]), 0);
    adv();

    // Reset while waiting for the response aborts silently.
    drive_idle();
    ifv = 1'b1; if_addr = 32'h8000_0080;
    settle();
    adv();
    ifv = 1'b0; mrr = 1'b1;
    settle();
    adv();
    mrr = 1'b0; i_rst_n = 1'b0; mrv = 1'b1; mem_rdata = 32'h7777_7777;
    settle();
    chk("rstresp no resp", 32'(if_rv[0]), 0);
    adv();
    i_rst_n = 1'b1; mrv = 1'b0; ifv = 1'b1; if_addr = 32'h8000_0100;
    settle();
    chk("rstresp busy cleared", 32'(busy[0]), 0);
    chk("rstresp re-accept", 32'(if_rdy[0]), 1);
    adv();
    ifv = 1'b0; mrr = 1'b1;
    settle();
    chk("rstresp mem_addr", mem_addr[0], 32'h8000_0100);
    adv();
    mrr = 1'b0; mrv = 1'b1; mem_rdata = 32'h0000_0013;
    settle();
    chk("rstresp served", 32'(if_rv[0]), 1);
    chk("rstresp rdata", if_rd[0], 32'h0000_0013);
    adv();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      i_rst_n   = ($urandom_range(0, 199) != 0);
      ifv       = ($urandom_range(0, 2) != 0);
      lsv       = ($urandom_range(0, 2) != 0);
      if_addr   = $urandom;
      ls_addr   = $urandom;
      ls_wen    = 1'($urandom);
      ls_wdata  = $urandom;
      ls_wmask  = 4'($urandom);
      mrr       = 1'($urandom);
      mrv       = ($urandom_range(0, 4) == 0);
      merr      = 1'($urandom);
      mem_rdata = $urandom;
      settle();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
